// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV64I core
// Optional illegal-opcode trap: define MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int          CNT_W       = 32,
  parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_src,
  output logic             mdr_we,
  output logic             reg_we,
  output logic [1:0]       wb_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_jump,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR, CLS_OP, CLS_OPIMM, CLS_ILLEGAL
  } cls_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC, S_ALUWB, S_BRANCH, S_JALR
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  // The trap target is applied by the PC mux; the PC is 4-byte aligned.
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("TRAP_VECTOR must be 4-byte aligned");
  end

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'b0000011: classify = CLS_LOAD;
      7'b0100011: classify = CLS_STORE;
      7'b1100011: classify = CLS_BRANCH;
      7'b1100111: classify = CLS_JALR;
      7'b0110011: classify = CLS_OP;
      7'b0010011: classify = CLS_OPIMM;
      default:    classify = CLS_ILLEGAL;
    endcase
  endfunction

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls, sel_cls;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[31:7];
  assign dec_cls = classify(instr[6:0]);
  assign instret = instret_q;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    instret_d = instret_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = 1'b0;
    mdr_we    = 1'b0;
    reg_we    = 1'b0;
    wb_src    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          CLS_LOAD, CLS_STORE: state_d = S_MEMADDR;
          CLS_OP, CLS_OPIMM:   state_d = S_EXEC;
          CLS_BRANCH:          state_d = S_BRANCH;
          CLS_JALR:            state_d = S_JALR;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:             state_d = S_TRAP;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR: begin
        alu_src_b = 1'b1;
        state_d   = (cls_q == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we    = 1'b1;
        wb_src    = 2'd1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op    = 2'd2;
        alu_src_b = (cls_q == CLS_OPIMM);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we    = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op    = 2'd1;
        pc_we     = branch_taken;
        pc_src    = 2'd1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_JALR: begin
        alu_src_b = 1'b1;
        reg_we    = 1'b1;
        wb_src    = 2'd2;
        pc_we     = 1'b1;
        pc_src    = 2'd1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal = 1'b1;
        pc_we   = 1'b1;
        pc_src  = 2'd2;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate type follows instr live in DECODE, then the latched class.
  always_comb begin
    sel_cls = cls_q;
    if (state_q == S_FETCH) sel_cls = CLS_NONE;
    else if (state_q == S_DECODE) sel_cls = dec_cls;
    is_load   = (sel_cls == CLS_LOAD) || (sel_cls == CLS_OPIMM);
    is_store  = (sel_cls == CLS_STORE);
    is_branch = (sel_cls == CLS_BRANCH);
    is_jump   = (sel_cls == CLS_JALR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;
  localparam int K_LOAD = 0, K_STORE = 1, K_BRANCH = 2, K_JALR = 3, K_OP = 4, K_OPIMM = 5, K_ILL = 6;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam int TRAP_EN = 1;
`else
  localparam int TRAP_EN = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic mem_ready = 1'b0, branch_taken = 1'b0;
  logic ir_we, pc_we, mem_req, mem_we, addr_src, mdr_we, reg_we, alu_src_b;
  logic is_load, is_store, is_branch, is_jump, illegal;
  logic [1:0] pc_src, wb_src, alu_op;
  logic [CNT_W-1:0] instret;

  int checks = 0, errors = 0, exp_instret = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .mdr_we(mdr_we),
    .reg_we(reg_we), .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_instr(input int k);
    logic [6:0] op;
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_LOAD:   op = 7'b0000011;
      K_STORE:  op = 7'b0100011;
      K_BRANCH: op = 7'b1100011;
      K_JALR:   op = 7'b1100111;
      K_OP:     op = 7'b0110011;
      K_OPIMM:  op = 7'b0010011;
      default: begin
        op = 7'b1111111;
        while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 ||
               op == 7'b1100111 || op == 7'b0110011 || op == 7'b0010011)
          op = 7'($urandom);
      end
    endcase
    return {r[31:7], op};
  endfunction

  // {is_load, is_store, is_branch, is_jump} expected while the instruction is in flight
  function automatic logic [3:0] sel_of(input int k);
    case (k)
      K_LOAD, K_OPIMM: return 4'b1000;
      K_STORE:         return 4'b0100;
      K_BRANCH:        return 4'b0010;
      K_JALR:          return 4'b0001;
      default:         return 4'b0000;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] iw, input int k, input int fw, input int mw,
                           input bit bt, input int abort_at);
    int kf, m, total;
    int ir_cnt, ir_cyc, pc_cnt, pcsrc_sum, reg_cnt, wb_at_reg, mdr_cnt, memwe_cnt;
    int addr1_cnt, fetch_req_cnt, sel_bad, ill_cnt, same_cnt, op_at, srcb_at;
    bit is_mem;
    kf = fw + 1; m = mw + 1;
    is_mem = (k == K_LOAD || k == K_STORE);
    case (k)
      K_OP, K_OPIMM:    total = kf + 3;
      K_LOAD:           total = kf + 3 + m;
      K_STORE:          total = kf + 2 + m;
      K_BRANCH, K_JALR: total = kf + 2;
      default:          total = kf + 1 + TRAP_EN;
    endcase
    ir_cnt = 0; ir_cyc = -1; pc_cnt = 0; pcsrc_sum = 0; reg_cnt = 0; wb_at_reg = -1;
    mdr_cnt = 0; memwe_cnt = 0; addr1_cnt = 0; fetch_req_cnt = 0; sel_bad = 0;
    ill_cnt = 0; same_cnt = 0; op_at = -1; srcb_at = -1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      instr = iw;
      if (c < kf) mem_ready = (c == kf - 1);
      else if (is_mem && c >= kf + 2 && c < kf + 2 + m) mem_ready = (c == kf + 1 + m);
      else mem_ready = 1'($urandom);
      branch_taken = (c == kf + 1) ? bt : 1'($urandom);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_req", mem_req, 1);
        check("rst_addr_src", addr_src, 0);
        check("rst_instret", instret, 0);
        check("rst_sel", {is_load, is_store, is_branch, is_jump}, 0);
        exp_instret = 0;
        return;
      end
      #1;
      if (ir_we) begin ir_cnt++; ir_cyc = c; end
      if (pc_we) begin pc_cnt++; pcsrc_sum += pc_src; end
      if (reg_we) begin reg_cnt++; wb_at_reg = wb_src; end
      if (reg_we && pc_we) same_cnt++;
      if (mdr_we) mdr_cnt++;
      if (mem_req && mem_we) memwe_cnt++;
      if (mem_req && addr_src) addr1_cnt++;
      if (mem_req && !addr_src) fetch_req_cnt++;
      if (illegal) ill_cnt++;
      if ({is_load, is_store, is_branch, is_jump} != ((c < kf) ? 4'b0 : sel_of(k))) sel_bad++;
      if (c == kf + 1) begin op_at = alu_op; srcb_at = alu_src_b; end
    end
    if (k != K_ILL) exp_instret = (exp_instret + 1) % (1 << CNT_W);
    check("ir_we_n", ir_cnt, 1);
    check("ir_we_cyc", ir_cyc, kf - 1);
    check("fetch_req", fetch_req_cnt, kf);
    check("pc_we_n", pc_cnt, 1 + ((k == K_BRANCH) ? int'(bt) : 0) + ((k == K_JALR) ? 1 : 0)
                              + ((k == K_ILL) ? TRAP_EN : 0));
    check("pc_src_sum", pcsrc_sum, ((k == K_BRANCH) ? int'(bt) : 0) + ((k == K_JALR) ? 1 : 0)
                                   + ((k == K_ILL) ? 2 * TRAP_EN : 0));
    check("reg_we_n", reg_cnt, (k == K_OP || k == K_OPIMM || k == K_LOAD || k == K_JALR) ? 1 : 0);
    check("wb_src", wb_at_reg, (k == K_LOAD) ? 1 : (k == K_JALR) ? 2 :
                               (k == K_OP || k == K_OPIMM) ? 0 : -1);
    check("jalr_same", same_cnt, (k == K_JALR) ? 1 : 0);
    check("mdr_we_n", mdr_cnt, (k == K_LOAD) ? 1 : 0);
    check("mem_we_n", memwe_cnt, (k == K_STORE) ? m : 0);
    check("addr1_n", addr1_cnt, is_mem ? m : 0);
    check("sel_bad", sel_bad, 0);
    check("illegal_n", ill_cnt, (k == K_ILL) ? TRAP_EN : 0);
    if (k != K_ILL)
      check("alu_op", op_at, (k == K_OP || k == K_OPIMM) ? 2 : (k == K_BRANCH) ? 1 : 0);
    if (k != K_ILL && k != K_BRANCH)
      check("alu_src_b", srcb_at, (k == K_OP) ? 0 : 1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("post_fetch", {mem_req, addr_src, mem_we, reg_we}, 4'b1000);
    check("post_sel", {is_load, is_store, is_branch, is_jump}, 0);
    check("instret", instret, exp_instret);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_req", mem_req, 1);
    check("reset_ctrl", {ir_we, pc_we, mem_we, addr_src, mdr_we, reg_we, illegal}, 0);
    check("reset_sel", {is_load, is_store, is_branch, is_jump}, 0);
    check("reset_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h00500093, K_OPIMM, 0, 0, 1'b0, -1);
    run_instr(make_instr(K_LOAD), K_LOAD, 0, 3, 1'b0, -1);
    run_instr(make_instr(K_BRANCH), K_BRANCH, 0, 0, 1'b0, -1);
    run_instr(make_instr(K_BRANCH), K_BRANCH, 1, 0, 1'b1, -1);
    run_instr(32'h000080E7, K_JALR, 0, 0, 1'b0, -1);
    run_instr(32'h0000007F, K_ILL, 0, 0, 1'b0, -1);
    run_instr(make_instr(K_STORE), K_STORE, 0, 2, 1'b0, -1);
    run_instr(make_instr(K_STORE), K_STORE, 0, 3, 1'b0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      run_instr(make_instr(k), k, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
